// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter output path: the sample type and width
// also used by the filter, the default decimator configuration, and the
// warm-up/run state encoding.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int DEF_DECIM  = 4;
  localparam int DEF_WARMUP = 12;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : fir_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with extra-MSB pointers. A write while full is accepted only
// when a read happens on the same edge; otherwise it is ignored (the caller
// decides what a rejected write means).
//
// Ports:
//   clk     in   rising-edge clock
//   rstN    in   synchronous reset, active-low (pointers only)
//   wrEn    in   write request
//   wrData  in   DW  data written at the tail
//   rdEn    in   read request; ignored while empty
//   rdData  out  DW  head entry (undefined while empty)
//   full    out  all DEPTH entries occupied
//   empty   out  no entries occupied
//   level   out  $clog2(DEPTH)+1  occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     wrEn,
  input  logic [DW-1:0]            wrData,
  input  logic                     rdEn,
  output logic [DW-1:0]            rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_rd;
  logic          w_do_wr;

  // The extra pointer MSB tells a full FIFO (one lap ahead) from an empty one.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level  = r_wr_ptr - r_rd_ptr;

  assign w_do_rd = rdEn && !empty;
  // A same-edge read frees the slot, so a full FIFO can still take the write.
  assign w_do_wr = wrEn && (!full || w_do_rd);

  assign rdData = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // written, since the pointers define which ones are valid.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wrData;
  end

endmodule : sync_fifo

// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
// Sits behind the FIR filter, which produces one signed sample per clock with
// no strobe. Discards the first WARMUP post-reset samples (filter pipeline
// fill), keeps one sample in every DECIM, and buffers kept samples in a FIFO
// exposed as a valid/ready stream. The filter is never stalled: a kept sample
// that finds the FIFO full (and no pop on that edge) is dropped and flagged.
//
// Ports:
//   clk          in   rising-edge clock, shared with the filter
//   rstN         in   synchronous reset, active-low
//   inData       in   DW  signed filter output, one sample per clk
//   outData      out  DW  signed head sample, 0 while outValid=0
//   outValid     out  FIFO non-empty
//   outReady     in   sink accepts; pop on edges with outValid&outReady
//   level        out  $clog2(DEPTH)+1  FIFO occupancy
//   overflow     out  sticky drop flag
//   clrOverflow  in   clears overflow (a drop on the same edge wins)
// -----------------------------------------------------------------------------
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DW     = SAMPLE_W,
  parameter int DECIM  = DEF_DECIM,
  parameter int WARMUP = DEF_WARMUP,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic signed [DW-1:0]   inData,
  output logic signed [DW-1:0]   outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clrOverflow
);

  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PH_W = (DECIM  > 1) ? $clog2(DECIM)  : 1;

  state_t            r_state;
  logic [WC_W-1:0]   r_warm_cnt;
  logic [PH_W-1:0]   r_phase;
  logic              r_overflow;

  logic              w_keep;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [DW-1:0]     w_rd_data;

  assign w_keep = (r_state == RUN) && (r_phase == '0);
  // Pop only counts when something is presented; ready while empty is ignored.
  assign w_pop  = !w_empty && outReady;
  assign w_drop = w_keep && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      // With no warm-up the very first edge after reset is already a RUN edge.
      r_state    <= (WARMUP == 0) ? RUN : WARM;
      r_warm_cnt <= '0;
      r_phase    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        WARM: begin
          r_warm_cnt <= r_warm_cnt + 1'b1;
          if (r_warm_cnt == WC_W'(WARMUP - 1)) r_state <= RUN;
        end
        RUN: begin
          r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + 1'b1;
        end
        default: r_state <= WARM;
      endcase

      if (w_drop)           r_overflow <= 1'b1;
      else if (clrOverflow) r_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstN   (rstN),
    .wrEn   (w_keep),
    .wrData (inData),
    .rdEn   (outReady),
    .rdData (w_rd_data),
    .full   (w_full),
    .empty  (w_empty),
    .level  (level)
  );

  assign outValid = !w_empty;
  assign outData  = w_empty ? '0 : w_rd_data;
  assign overflow = r_overflow;

endmodule : fir_decimator

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
// Three decimator instances share one stimulus stream:
//   u0: DECIM=4 WARMUP=12   u1: DECIM=1 WARMUP=0   u2: DECIM=3 WARMUP=12
// A behavioural scoreboard (per-instance circular queue) tracks every instance
// each cycle; a table of hand-derived vectors and a few hand-written sequences
// pin the corner cases independently of that model.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

  localparam int N_DUT = 3;
  localparam int MD    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstN;
  logic signed [15:0] inData;
  logic               outReady;
  logic               clrOverflow;

  logic signed [15:0] w_data  [N_DUT];
  logic               w_valid [N_DUT];
  logic [3:0]         w_level [N_DUT];
  logic               w_ovf   [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;

  fir_decimator #(.DW(16), .DECIM(4), .WARMUP(12), .DEPTH(8)) u0 (
    .clk(clk), .rstN(rstN), .inData(inData), .outData(w_data[0]),
    .outValid(w_valid[0]), .outReady(outReady), .level(w_level[0]),
    .overflow(w_ovf[0]), .clrOverflow(clrOverflow));

  fir_decimator #(.DW(16), .DECIM(1), .WARMUP(0), .DEPTH(8)) u1 (
    .clk(clk), .rstN(rstN), .inData(inData), .outData(w_data[1]),
    .outValid(w_valid[1]), .outReady(outReady), .level(w_level[1]),
    .overflow(w_ovf[1]), .clrOverflow(clrOverflow));

  fir_decimator #(.DW(16), .DECIM(3), .WARMUP(12), .DEPTH(8)) u2 (
    .clk(clk), .rstN(rstN), .inData(inData), .outData(w_data[2]),
    .outValid(w_valid[2]), .outReady(outReady), .level(w_level[2]),
    .overflow(w_ovf[2]), .clrOverflow(clrOverflow));

  // ---------------------------------------------------------------------------
  // Scoreboard model
  // ---------------------------------------------------------------------------
  int dec_tab [N_DUT] = '{4, 1, 3};
  int wu_tab  [N_DUT] = '{12, 0, 12};

  logic signed [15:0] sb_mem [N_DUT][MD];
  int sb_head  [N_DUT];
  int sb_cnt   [N_DUT];
  int m_warm   [N_DUT];
  int m_phase  [N_DUT];
  bit m_run    [N_DUT];
  bit m_ovf    [N_DUT];
  bit m_dropped[N_DUT];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < N_DUT; k++) begin
      bit keep;
      bit pop;
      if (!rstN) begin
        sb_head[k]   = 0;
        sb_cnt[k]    = 0;
        m_warm[k]    = 0;
        m_phase[k]   = 0;
        m_run[k]     = (wu_tab[k] == 0);
        m_ovf[k]     = 1'b0;
        m_dropped[k] = 1'b0;
      end else begin
        keep = m_run[k] && (m_phase[k] == 0);
        pop  = (sb_cnt[k] > 0) && outReady;
        if (m_run[k]) begin
          m_phase[k] = (m_phase[k] + 1) % dec_tab[k];
        end else begin
          if (m_warm[k] == wu_tab[k] - 1) m_run[k] = 1'b1;
          m_warm[k]++;
        end
        if (keep && sb_cnt[k] == MD && !pop) begin
          m_ovf[k]     = 1'b1;
          m_dropped[k] = 1'b1;
        end else begin
          if (clrOverflow) m_ovf[k] = 1'b0;
          if (keep) begin
            sb_mem[k][(sb_head[k] + sb_cnt[k]) % MD] = inData;
            sb_cnt[k]++;
          end
        end
        if (pop) begin
          sb_head[k] = (sb_head[k] + 1) % MD;
          sb_cnt[k]--;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < N_DUT; k++) begin
      int exp_data;
      exp_data = (sb_cnt[k] > 0) ? int'(sb_mem[k][sb_head[k]]) : 0;
      check($sformatf("u%0d.outValid", k), int'(w_valid[k]), int'(sb_cnt[k] > 0));
      check($sformatf("u%0d.outData", k),  int'(w_data[k]),  exp_data);
      check($sformatf("u%0d.level", k),    int'(w_level[k]), sb_cnt[k]);
      check($sformatf("u%0d.overflow", k), int'(w_ovf[k]),   int'(m_ovf[k]));
    end
  endtask

  task automatic do_reset();
    rstN        = 1'b0;
    outReady    = 1'b0;
    clrOverflow = 1'b0;
    inData      = '0;
    cycle();
    rstN = 1'b1;
  endtask

  // Ramp from 0 with the sink always ready; u0 must discard 0..11 and then
  // present 12, 16, ... each for exactly one cycle.
  task automatic ramp_u0();
    rstN        = 1'b1;
    outReady    = 1'b1;
    clrOverflow = 1'b0;
    for (int c = 0; c < 40; c++) begin
      inData = 16'(c);
      cycle();
      if (c == 11) check("u0 warm-up discard", int'(w_valid[0]), 0);
      if (c == 12) begin
        check("u0 first kept valid", int'(w_valid[0]), 1);
        check("u0 first kept data",  int'(w_data[0]),  12);
      end
      if (c == 13) check("u0 popped after one cycle", int'(w_valid[0]), 0);
      if (c == 16) check("u0 second kept data", int'(w_data[0]), 16);
      if (c == 20) check("u0 third kept data",  int'(w_data[0]), 20);
    end
    check("u0 overflow after ramp", int'(w_ovf[0]), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for u1 (DECIM=1, WARMUP=0)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit rst_n;
    int din;
    bit rdy;
    bit clr;
    bit e_valid;
    int e_data;
    int e_level;
    bit e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit r, input int d, input bit rdy, input bit clr,
                         input bit ev, input int ed, input int el, input bit eo);
    vec_t v;
    v.rst_n = r;   v.din = d;      v.rdy = rdy;     v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_level = el;  v.e_ovf = eo;
    vecs.push_back(v);
  endtask

  int drain_exp [8] = '{6, 7, 8, 9, 10, 11, 14, 16};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill the table: saturate, drain while refilling, then full-with-pop,
    // set/clear collisions and a drain showing the dropped samples are gone.
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add_vec(1, i, 0, 0, 1, 0, (i + 1 > 8) ? 8 : i + 1, i >= 8);
    for (int j = 0; j < 8; j++)
      add_vec(1, 10 + j, 1, 0, 1, (j < 7) ? j + 1 : 10, 8, 1);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add_vec(1, i, 0, 0, 1, 0, i + 1, 0);
    for (int i = 8; i < 12; i++)
      add_vec(1, i, 1, 0, 1, i - 7, 8, 0);
    add_vec(1, 12, 0, 0, 1, 4, 8, 1);
    add_vec(1, 13, 0, 1, 1, 4, 8, 1);
    add_vec(1, 14, 1, 1, 1, 5, 8, 0);
    add_vec(1, 15, 0, 0, 1, 5, 8, 1);
    for (int j = 0; j < 8; j++)
      add_vec(1, 16 + j, 1, 0, 1, drain_exp[j], 8, 1);

    // Scenario: reset state, warm-up and DECIM=4 ramp.
    do_reset();
    check("u0 reset outValid", int'(w_valid[0]), 0);
    check("u0 reset level",    int'(w_level[0]), 0);
    ramp_u0();

    // Scenario: DECIM=1, no warm-up, every sample passes through once.
    do_reset();
    outReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      inData = 16'(100 + c);
      cycle();
      check("u1 passthrough data",  int'(w_data[1]),  100 + c);
      check("u1 passthrough level", int'(w_level[1]), 1);
    end

    // Table-driven corner cases on u1.
    foreach (vecs[i]) begin
      rstN        = vecs[i].rst_n;
      inData      = 16'(vecs[i].din);
      outReady    = vecs[i].rdy;
      clrOverflow = vecs[i].clr;
      cycle();
      check($sformatf("vec%0d outValid", i), int'(w_valid[1]), int'(vecs[i].e_valid));
      check($sformatf("vec%0d outData", i),  int'(w_data[1]),  vecs[i].e_data);
      check($sformatf("vec%0d level", i),    int'(w_level[1]), vecs[i].e_level);
      check($sformatf("vec%0d overflow", i), int'(w_ovf[1]),   int'(vecs[i].e_ovf));
    end

    // Scenario: mid-stream reset with five entries buffered.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      inData = 16'(c);
      cycle();
    end
    check("u1 level before reset", int'(w_level[1]), 5);
    rstN = 1'b0;
    cycle();
    check("mid reset outValid", int'(w_valid[1]), 0);
    check("mid reset outData",  int'(w_data[1]),  0);
    check("mid reset level",    int'(w_level[1]), 0);
    check("mid reset overflow", int'(w_ovf[1]),   0);
    ramp_u0();

    // Scenario: random back-pressure, DECIM=3 on u2.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      inData   = 16'(c);
      outReady = 1'($urandom_range(0, 1));
      cycle();
    end
    check("u2 overflow iff drop", int'(w_ovf[2]), int'(m_dropped[2]));
    check("u1 overflow iff drop", int'(w_ovf[1]), int'(m_dropped[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fir_decimator
